// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam logic [3:0] MID_START = 4'd7;
    localparam logic [3:0] MID_BIT   = 4'd15;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial input, plus a 2-of-3 sample
// voter when UART_RX_MAJORITY_EN is defined.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_i,
`ifdef UART_RX_MAJORITY_EN
    input  logic tick_i,
`endif
    input  logic rxd_i,
    output logic rxs_o,
    output logic vote_o
);

    logic ff1_q;
    logic ff2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ff1_q <= 1'b1;
            ff2_q <= 1'b1;
        end else begin
            ff1_q <= rxd_i;
            ff2_q <= ff1_q;
        end
    end

    assign rxs_o = ff2_q;

`ifdef UART_RX_MAJORITY_EN
    // rxs on the two previous ticks; voted with the current one
    logic [1:0] hist_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q <= 2'b11;
        end else if (tick_i) begin
            hist_q <= {hist_q[0], ff2_q};
        end
    end

    assign vote_o = (hist_q[1] & hist_q[0]) |
                    (hist_q[1] & ff2_q) |
                    (hist_q[0] & ff2_q);
`else
    assign vote_o = ff2_q;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 8N1 with optional parity.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling.
module uart_rx
    import uart_pkg::*;
#(
    parameter int PARITY_BIT = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       UART_CLK_EN,
    input  logic       UART_RXD,
    output logic [7:0] DATA_OUT,
    output logic       DATA_VLD,
    output logic       FRAME_ERROR,
    output logic       PARITY_ERROR,
    output logic       BUSY,
    output logic [2:0] STATE
);

`ifdef UART_RX_MAJORITY_EN
    // the vote completes one tick after the bit centre
    localparam logic [3:0] SAMP_LAG = 4'd1;
`else
    localparam logic [3:0] SAMP_LAG = 4'd0;
`endif

    localparam logic [3:0] START_PT = 4'(MID_START + SAMP_LAG);
    localparam logic [3:0] BIT_PT   = 4'(MID_BIT + SAMP_LAG);

    logic rxs;
    logic vote;

    uart_rx_sync u_sync (
        .clk_i  (CLK),
        .rst_i  (RST),
`ifdef UART_RX_MAJORITY_EN
        .tick_i (UART_CLK_EN),
`endif
        .rxd_i  (UART_RXD),
        .rxs_o  (rxs),
        .vote_o (vote)
    );

    rx_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       pmis_q, pmis_d;
    logic [7:0] dout_q, dout_d;
    logic       vld_q, vld_d;
    logic       ferr_q, ferr_d;
    logic       perr_q, perr_d;
    logic       par_exp;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            pmis_q  <= 1'b0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            pmis_q  <= pmis_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
        end
    end

    assign par_exp = (PARITY_BIT == PAR_ODD) ? ~^shift_q : ^shift_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pmis_d  = pmis_q;
        dout_d  = dout_q;
        vld_d   = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
        if (UART_CLK_EN) begin
            cnt_d = cnt_q + 4'd1;
            unique case (state_q)
                ST_IDLE: begin
                    if (!rxs) begin
                        cnt_d   = '0;
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_q == START_PT) begin
                        if (!vote) begin
                            // keep the counter phase-aligned to bit centres
                            cnt_d   = SAMP_LAG;
                            bit_d   = '0;
                            pmis_d  = 1'b0;
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (cnt_q == BIT_PT) begin
                        shift_d[bit_q] = vote;
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = (PARITY_BIT != PAR_NONE) ?
                                      ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (cnt_q == BIT_PT) begin
                        pmis_d  = (vote != par_exp);
                        state_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == BIT_PT) begin
                        if (vote) begin
                            dout_d = shift_q;
                            vld_d  = 1'b1;
                            perr_d = pmis_q;
                        end else begin
                            ferr_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign DATA_OUT     = dout_q;
    assign DATA_VLD     = vld_q;
    assign FRAME_ERROR  = ferr_q;
    assign PARITY_ERROR = perr_q;
    assign BUSY         = (state_q != ST_IDLE);
    assign STATE        = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: no-parity and even-parity receivers.
module tb_uart_rx;

    localparam int BIT = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] tdiv = 2'd0;
    logic       tick;
    logic       rxd0 = 1'b1;
    logic       rxd2 = 1'b1;

    logic [7:0] dout0, dout2;
    logic       vld0, ferr0, perr0, busy0;
    logic       vld2, ferr2, perr2, busy2;
    logic [2:0] state0, state2;

    int n_checks = 0;
    int n_fail   = 0;
    int n_vld0 = 0, n_ferr0 = 0, n_perr0 = 0;
    int n_vld2 = 0, n_ferr2 = 0;
    logic [7:0] q0[$];
    logic [7:0] d2_last = 8'h00;
    logic       perr2_last = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) tdiv <= tdiv + 2'd1;
    assign tick = (tdiv == 2'd3);

    uart_rx #(.PARITY_BIT(0)) dut0 (
        .CLK          (clk),
        .RST          (rst),
        .UART_CLK_EN  (tick),
        .UART_RXD     (rxd0),
        .DATA_OUT     (dout0),
        .DATA_VLD     (vld0),
        .FRAME_ERROR  (ferr0),
        .PARITY_ERROR (perr0),
        .BUSY         (busy0),
        .STATE        (state0)
    );

    uart_rx #(.PARITY_BIT(2)) dut2 (
        .CLK          (clk),
        .RST          (rst),
        .UART_CLK_EN  (tick),
        .UART_RXD     (rxd2),
        .DATA_OUT     (dout2),
        .DATA_VLD     (vld2),
        .FRAME_ERROR  (ferr2),
        .PARITY_ERROR (perr2),
        .BUSY         (busy2),
        .STATE        (state2)
    );

    always @(negedge clk) begin
        if (vld0) begin
            n_vld0 = n_vld0 + 1;
            q0.push_back(dout0);
            if (perr0) n_perr0 = n_perr0 + 1;
        end
        if (ferr0) n_ferr0 = n_ferr0 + 1;
        if (vld2) begin
            n_vld2 = n_vld2 + 1;
            d2_last = dout2;
            perr2_last = perr2;
        end
        if (ferr2) n_ferr2 = n_ferr2 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rxd2 = v;
        else     rxd0 = v;
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d,
                              input bit has_par, input bit par,
                              input bit stop);
        drive(sel, 1'b0);
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i]);
            wait_clk(BIT);
        end
        if (has_par) begin
            drive(sel, par);
            wait_clk(BIT);
        end
        drive(sel, stop);
        wait_clk(BIT);
        drive(sel, 1'b1);
    endtask

    initial begin
        logic [7:0] b5a;
        b5a = 8'h5A;

        wait_clk(6);
        check("rst_dout", dout0, 8'h00);
        check("rst_vld", vld0, 1'b0);
        check("rst_ferr", ferr0, 1'b0);
        check("rst_perr", perr0, 1'b0);
        check("rst_busy", busy0, 1'b0);
        check("rst_state", state0, 3'd0);
        rst = 1'b0;
        wait_clk(BIT);

        fork
            send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
            begin
                wait_clk(200);
                check("a5_busy_mid", busy0, 1'b1);
            end
        join
        wait_clk(8);
        check("a5_nvld", n_vld0, 1);
        check("a5_data", q0[0], 8'hA5);
        check("a5_nferr", n_ferr0, 0);
        check("a5_nperr", n_perr0, 0);
        check("a5_busy_end", busy0, 1'b0);
        wait_clk(BIT);

        send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
        wait_clk(8);
        check("b2b_nvld", n_vld0, 3);
        check("b2b_d0", q0[1], 8'h00);
        check("b2b_d1", q0[2], 8'hFF);
        wait_clk(BIT);

        rxd0 = 1'b0;
        wait_clk(16);
        check("fs_state_start", state0, 3'd1);
        rxd0 = 1'b1;
        wait_clk(2 * BIT);
        check("fs_state_idle", state0, 3'd0);
        check("fs_nvld", n_vld0, 3);
        check("fs_nferr", n_ferr0, 0);

        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        wait_clk(2 * BIT);
        check("fe_nferr", n_ferr0, 1);
        check("fe_nvld", n_vld0, 3);
        check("fe_dout_kept", dout0, 8'hFF);
        check("fe_state", state0, 3'd0);

        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        wait_clk(8);
        check("pe_bad_nvld", n_vld2, 1);
        check("pe_bad_data", d2_last, 8'h07);
        check("pe_bad_perr", perr2_last, 1'b1);
        wait_clk(BIT);
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        wait_clk(8);
        check("pe_ok_nvld", n_vld2, 2);
        check("pe_ok_data", d2_last, 8'h07);
        check("pe_ok_perr", perr2_last, 1'b0);
        check("pe_nferr", n_ferr2, 0);
        wait_clk(BIT);

        rxd0 = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 4; i++) begin
            rxd0 = b5a[i];
            wait_clk(BIT);
        end
        rxd0 = b5a[4];
        wait_clk(BIT / 2);
        check("mr_state_data", state0, 3'd2);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        check("mr_dout", dout0, 8'h00);
        check("mr_state", state0, 3'd0);
        check("mr_busy", busy0, 1'b0);
        check("mr_vld", vld0, 1'b0);
        rxd0 = 1'b1;
        wait_clk(2 * BIT);
        check("mr_no_vld", n_vld0, 3);
        send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
        wait_clk(8);
        check("mr_next_nvld", n_vld0, 4);
        check("mr_next_data", q0[3], 8'h81);
        check("mr_next_nferr", n_ferr0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the stage directly downstream of the UART transmitter; consumes its serial UART_TXD line on UART_RXD.
- Oversamples the line with the shared 16x UART_CLK_EN tick and validates the start bit at mid-bit.
- Assembles 8 data bits LSB first, with optional parity, and checks the stop bit.
- Delivers each byte as a one-cycle valid pulse plus error flags to the decode logic downstream.

Parameters:
- PARITY_BIT, 0: parity mode. 0 = none, 1 = odd, 2 = even. Must match the transmitter setting.

Ports:
- CLK  in  1  system clock; only clock.
- RST  in  1  synchronous, active-high reset.
- UART_CLK_EN  in  1  one-CLK pulse at 16x baud, shared with the transmitter.
- UART_RXD  in  1  asynchronous serial input; idles high.
- DATA_OUT  out  8  last received byte.
- DATA_VLD  out  1  one-cycle pulse; DATA_OUT is valid.
- FRAME_ERROR  out  1  one-cycle pulse; stop bit sampled low.
- PARITY_ERROR  out  1  one-cycle pulse, coincident with DATA_VLD; parity mismatch.
- BUSY  out  1  high whenever the FSM is not in IDLE.
- STATE  out  3  present FSM state, for debug.

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RST).
- Reset values: DATA_OUT=0x00, DATA_VLD=0, FRAME_ERROR=0, PARITY_ERROR=0, BUSY=0, STATE=IDLE(0). Synchronizer flops reset to 1. Tick counter, bit counter and shift register reset to 0.
- RST mid-frame: everything returns to the reset values on the next CLK edge. No partial byte is emitted.
- Synchronizer: UART_RXD passes through 2 flops clocked every CLK; the result is rxs (2-CLK latency).
- Counters advance only in cycles where UART_CLK_EN=1; otherwise all counters hold.
- Tick counter is 4 bits and wraps 15->0.
- States: IDLE(0), START(1), DATA(2), PARITY(3), STOP(4).
- IDLE:
  - On a tick with rxs=0: clear tick counter, go to START.
- START:
  - Count ticks. On the tick where counter==7 (mid start bit), sample.
  - Sample 0: clear counter and bit count, go to DATA.
  - Sample 1: false start; return to IDLE with no flags.
- DATA:
  - Sample on the tick where counter==15 (16 ticks later, i.e. mid-bit).
  - Shift the sample into bit[bit_count], LSB first; increment the 3-bit bit count.
  - After bit 7 (bit_count wraps 7->0): go to PARITY if PARITY_BIT!=0, else STOP.
- PARITY:
  - Sample on counter==15.
  - Expected bit: odd mode = ~^data; even mode = ^data.
  - Latch the mismatch, go to STOP.
- STOP:
  - Sample on counter==15.
  - Sample 1: next CLK, DATA_OUT <= shift register, DATA_VLD=1, PARITY_ERROR=latched mismatch.
  - Sample 0: FRAME_ERROR=1, DATA_OUT unchanged, DATA_VLD=0, PARITY_ERROR=0.
  - Either way, go to IDLE.
- Back-to-back frames: because stop is sampled at mid-bit and the FSM returns to IDLE immediately, a start edge arriving right after the stop bit is caught.
- Framing-error recovery: if the line is still 0 after a framing error, IDLE sees rxs=0 and re-enters START. A line held low therefore yields a repeated FRAME_ERROR roughly every 10 bits, by design.
- Output timing: DATA_VLD, FRAME_ERROR and PARITY_ERROR are registered, high exactly 1 CLK, and never overlap a reset.
- No buffering: the consumer must capture DATA_OUT on DATA_VLD. DATA_OUT holds until the next valid byte.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- When defined:
  - Each sample point uses a 2-of-3 majority of rxs taken on ticks counter-1, counter and counter+1 (START: ticks 6/7/8; other states: 14/15/0).
  - The decision is registered on the third tick, so each state transition moves one tick later.
  - Sample points are unchanged relative to the bit centre.
- When undefined: a single sample at the tick points listed above.

Decomposition:
- Package uart_pkg:
  - State encoding constants (IDLE..STOP).
  - Parity mode constants: PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2.
  - Mid-bit tick constants: 7 and 15.
- Sub-module uart_rx_sync:
  - 2-FF synchronizer plus the optional majority voter.
  - Outputs rxs and the voted sample.
- FSM, counters, shift register and output registers live in uart_rx.

Test Plan:
- Loopback from transmitter (PARITY_BIT=0), send 0xA5 -> one DATA_VLD with DATA_OUT=0xA5, no error pulses, BUSY high only during the frame.
- 0x00 then 0xFF back-to-back with no idle gap -> two DATA_VLD pulses, values 0x00 and 0xFF, second frame not lost.
- UART_RXD low for 4 ticks then high -> START aborts to IDLE; no DATA_VLD or FRAME_ERROR; STATE back to 0.
- Frame 0x3C with stop bit forced 0 -> FRAME_ERROR pulse, DATA_VLD=0, DATA_OUT keeps its previous value.
- PARITY_BIT=2 (even), send 0x07 with parity bit 0 (wrong) -> DATA_VLD with DATA_OUT=0x07 and PARITY_ERROR=1. Correct parity bit 1 -> PARITY_ERROR=0.
- RST pulsed during data bit 4 of 0x5A -> all outputs return to their reset values the next cycle; no DATA_VLD; the following frame 0x81 is received correctly.
